// File: rtl/tdisp_pkg.sv
// Shared segment patterns, slot numbering and BCD decode for the temperature display scanner.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package tdisp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_UNIT = 3'd0;
    localparam slot_t SLOT_ONES = 3'd1;
    localparam slot_t SLOT_TENS = 3'd2;
    localparam slot_t SLOT_HUND = 3'd3;
    localparam slot_t SLOT_THOU = 3'd4;
    localparam slot_t SLOT_SIGN = 3'd5;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tdisp_scan_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show 'E'.
module seg7_decode
    import tdisp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/tdisp_scan.sv
// Six-position multiplexed temperature display: [-][thou][hund][tens.][ones][C/F].
// Optional brightness control on the anode duty cycle with TDISP_SCAN_DIM_EN.
module tdisp_scan
    import tdisp_pkg::*;
#(
    parameter int DIV  = 100000,
    parameter int NDIG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [3:0]      thousands,
    input  logic [3:0]      hundreds,
    input  logic [3:0]      tens,
    input  logic [3:0]      ones,
    input  logic            sign,
    input  logic            c_f,
`ifdef TDISP_SCAN_DIM_EN
    input  logic [2:0]      bright,
`endif
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]   pre_q, pre_d;
    slot_t           slot_q, slot_d;
    logic [3:0]      th_q, th_d, hu_q, hu_d, te_q, te_d, on_q, on_d;
    logic            sign_q, sign_d, cf_q, cf_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic [3:0]      dig;
    logic [6:0]      dig_seg;
    logic            blank_h, blank_t;
    logic            active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            slot_q <= SLOT_UNIT;
            th_q   <= '0;
            hu_q   <= '0;
            te_q   <= '0;
            on_q   <= '0;
            sign_q <= 1'b0;
            cf_q   <= 1'b0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            slot_q <= slot_d;
            th_q   <= th_d;
            hu_q   <= hu_d;
            te_q   <= te_d;
            on_q   <= on_d;
            sign_q <= sign_d;
            cf_q   <= cf_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    always_comb begin
        pre_d  = pre_q + 1'b1;
        slot_d = slot_q;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            slot_d = (slot_q == SLOT_SIGN) ? SLOT_UNIT : slot_q + 3'd1;
        end
    end

    // Capture is independent of the scan position, so a load on a wrap edge
    // lands together with the slot change and the next slot is already clean.
    always_comb begin
        th_d   = th_q;
        hu_d   = hu_q;
        te_d   = te_q;
        on_d   = on_q;
        sign_d = sign_q;
        cf_d   = cf_q;
        if (load) begin
            th_d   = thousands;
            hu_d   = hundreds;
            te_d   = tens;
            on_d   = ones;
            sign_d = sign;
            cf_d   = c_f;
        end
    end

    always_comb begin
        case (slot_q)
            SLOT_TENS: dig = te_q;
            SLOT_HUND: dig = hu_q;
            SLOT_THOU: dig = th_q;
            default:   dig = on_q;
        endcase
    end

    seg7_decode u_dec (
        .bcd_i (dig),
        .seg_o (dig_seg)
    );

    assign blank_t = (th_q == 4'd0);
    assign blank_h = blank_t && (hu_q == 4'd0);

    // The minus sits in the first blanked position left of the leading digit.
    always_comb begin
        dp_d = 1'b1;
        case (slot_q)
            SLOT_UNIT: seg_d = cf_q ? SEG_F : SEG_C;
            SLOT_ONES: seg_d = dig_seg;
            SLOT_TENS: begin
                seg_d = dig_seg;
                dp_d  = 1'b0;
            end
            SLOT_HUND: seg_d = !blank_h ? dig_seg
                             : (sign_q ? SEG_MINUS : SEG_BLANK);
            SLOT_THOU: seg_d = !blank_t ? dig_seg
                             : ((sign_q && !blank_h) ? SEG_MINUS : SEG_BLANK);
            default:   seg_d = (sign_q && !blank_t) ? SEG_MINUS : SEG_BLANK;
        endcase
    end

`ifdef TDISP_SCAN_DIM_EN
    logic [31:0] thr_q, thr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) thr_q <= '0;
        else        thr_q <= thr_d;
    end

    always_comb begin
        thr_d = thr_q;
        if (pre_q == '0)
            thr_d = 32'd1 + ((32'(bright) + 32'd1) * 32'(DIV - 1)) / 32'd8;
    end

    assign active = (pre_q != '0) && (32'(pre_q) < thr_q);
`else
    assign active = (pre_q != '0);
`endif

    // Count 0 of every slot keeps all anodes dark to avoid ghosting.
    always_comb begin
        an_d = '1;
        if (active)
            an_d[slot_q] = 1'b0;
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_tdisp_scan.sv
// Scoreboard bench for tdisp_scan with DIV=4: expected slot patterns are queued at load time.
module tb_tdisp_scan;

    localparam int DIV  = 4;
    localparam int NDIG = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [3:0]      thousands = '0, hundreds = '0, tens = '0, ones = '0;
    logic            sign = 1'b0, c_f = 1'b0;
`ifdef TDISP_SCAN_DIM_EN
    logic [2:0]      bright = 3'd7;
`endif
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    tdisp_scan #(.DIV(DIV), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .sign      (sign),
        .c_f       (c_f),
`ifdef TDISP_SCAN_DIM_EN
        .bright    (bright),
`endif
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // Expected {seg,dp} for slots 0..5, from the position of the leading lit digit.
    task automatic push_frame(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                              input logic [3:0] on, input logic sg, input logic cf);
        int msd;
        logic [3:0] d;
        msd = (th != 0) ? 4 : ((hu != 0) ? 3 : 2);
        exp_q.push_back({(cf ? 7'h0E : 7'h46), 1'b1});
        exp_q.push_back({seg_of(on), 1'b1});
        exp_q.push_back({seg_of(te), 1'b0});
        for (int k = 3; k <= 5; k++) begin
            d = (k == 3) ? hu : th;
            if (k <= msd)                  exp_q.push_back({seg_of(d), 1'b1});
            else if (sg && k == msd + 1)   exp_q.push_back({7'h3F, 1'b1});
            else                           exp_q.push_back({7'h7F, 1'b1});
        end
    endtask

    task automatic do_load(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                           input logic [3:0] on, input logic sg, input logic cf);
        @(negedge clk);
        thousands = th; hundreds = hu; tens = te; ones = on; sign = sg; c_f = cf;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_frame(th, hu, te, on, sg, cf);
    endtask

    // Returns at the first negedge of a fresh slot-0 active window.
    task automatic sync_fe();
        logic [NDIG-1:0] prev;
        bit ok;
        ok = 1'b0;
        prev = an;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev == 8'hFF && an == 8'hFE) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
        if (!ok) chk("sync_timeout", {24'd0, an}, 32'hFE);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] e;
        logic [7:0] an_exp;
        sync_fe();
        for (int s = 0; s < 6; s++) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("%s q_empty s%0d", tag, s), 32'd0, 32'd1);
                e = 8'h00;
            end else begin
                e = exp_q.pop_front();
            end
            an_exp = 8'hFF & ~(8'h01 << s);
            if (s > 0) begin
                @(negedge clk);
                chk($sformatf("%s guard s%0d", tag, s), {24'd0, an}, 32'hFF);
            end
            for (int c = 1; c <= 3; c++) begin
                if (!(s == 0 && c == 1)) @(negedge clk);
                chk($sformatf("%s s%0d c%0d", tag, s, c), {16'd0, an, seg, dp}, {16'd0, an_exp, e});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_guard", {24'd0, an}, 32'hFF);
        @(negedge clk);
        chk("post_rst_first", {16'd0, an, seg, dp}, {16'd0, 8'hFE, 7'h46, 1'b1});
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check_frame("zero");

        do_load(4'd0, 4'd2, 4'd5, 4'd3, 1'b0, 1'b0);
        check_frame("p25_3C");
        do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
        check_frame("m0_5F");
        do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        check_frame("m123_4");
        do_load(4'd0, 4'd0, 4'd0, 4'hB, 1'b0, 1'b0);
        check_frame("bad_ones");
        do_load(4'd0, 4'hA, 4'd1, 4'd2, 1'b1, 1'b0);
        check_frame("bad_hund");
        do_load(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
        check_frame("ones_1");

        // Load on the slot-0 -> slot-1 wrap edge.
        sync_fe();
        @(negedge clk);
        thousands = 4'd7; hundreds = 4'd7; tens = 4'd7; ones = 4'd7; sign = 1'b0; c_f = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrap_last_s0", {16'd0, an, seg, dp}, {16'd0, 8'hFE, 7'h46, 1'b1});
        @(negedge clk);
        chk("wrap_guard", {24'd0, an}, 32'hFF);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("wrap_s1 c%0d", c), {16'd0, an, seg, dp}, {16'd0, 8'hFD, 7'h78, 1'b1});
        end
        push_frame(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0);
        check_frame("sevens");

        // Asynchronous reset in the middle of an active window.
        sync_fe();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {24'd0, an}, 32'hFF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_dp", {31'd0, dp}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check_frame("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdisp_scan.md
Name: tdisp_scan

Overview:
- Time-multiplexed seven-segment driver that sits directly downstream of the temperature BCD conversion stage.
- Latches the BCD digits, sign and C/F unit selection, then scans six digit positions at a fixed refresh rate.
- Displays: floating minus, thousands, hundreds, tens with decimal point, ones (tenths), unit letter C or F.
- Drives the board's active-low anodes and segments.

Parameters:
- DIV, 100000: clock cycles per digit slot (100 MHz / 100000 = 1 kHz per digit); legal range 4 to 2^20.
- NDIG, 8: number of physical anodes driven; unused anodes are held off.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- load  in  1  single-cycle strobe; capture the digit inputs
- thousands  in  4  BCD digit
- hundreds  in  4  BCD digit
- tens  in  4  BCD digit
- ones  in  4  BCD digit (tenths of a degree)
- sign  in  1  1 = negative
- c_f  in  1  unit select, 0 = C, 1 = F
- an  out  NDIG  anode enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low on rst_n.
  - While rst_n = 0: an = all 1, seg = 7'h7F, dp = 1; prescaler = 0; slot index = 0; latched digits = 0; latched sign = 0; latched c_f = 0.
  - Reset asserted mid-scan blanks the outputs immediately.
- Capture: when load = 1 at a rising edge, all six inputs are registered together. The scan uses the new values from the next cycle. Inputs are ignored when load = 0.
- Prescaler: counts 0..DIV-1. At DIV-1 it wraps to 0 and the slot index advances 0,1,2,3,4,5,0. Wrap and load in the same cycle are independent; both take effect.
- Output timing:
  - an, seg and dp are registered, with one cycle of latency from the slot index.
  - Ghosting guard: during prescaler count 0 of each slot, an = all 1; the anode is active for the remaining DIV-1 cycles.
- Slot contents (slot i drives an[i] low):
  - slot 0: unit letter, C = 7'h46, F = 7'h0E; dp off.
  - slot 1: ones digit; dp off.
  - slot 2: tens digit; dp on (0).
  - slot 3: hundreds digit, blanked if thousands = 0 and hundreds = 0.
  - slot 4: thousands digit, blanked if thousands = 0.
  - slot 5: always blank, except when it holds the minus sign.
- Leading-zero blanking: tens is never blanked, so 0.0 displays as "0.0".
- Minus placement (sign = 1):
  - minus (7'h3F) goes in the blank slot immediately left of the most-significant lit digit: slot 3 if hundreds is blanked, slot 4 if only thousands is blanked, slot 5 otherwise.
  - sign = 0 leaves that slot blank.
- Digit decode:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - A BCD value of 10 to 15 displays E = 7'h06 and is exempt from blanking.
- Unused anodes: an[NDIG-1:6] = 1 at all times.

Optional Feature:
- Macro: TDISP_SCAN_DIM_EN.
- Enabled: adds input port bright [2:0]. Within each slot the anode is active only while 1 <= prescaler < 1 + ((bright+1)*(DIV-1))/8. The threshold is computed once per slot at prescaler count 0. bright = 7 gives the full DIV-1 cycles.
- Disabled: no bright port; full duty as described above.

Decomposition:
- Package tdisp_pkg holds:
  - the segment constants SEG_BLANK, SEG_MINUS, SEG_C, SEG_F, SEG_E;
  - the digit-to-segment decode function;
  - typedef slot_t (3-bit) and the SLOT_* constants.
- One sub-module, seg7_decode: combinational 4-bit BCD to 7-bit active-low pattern, instantiated once on the muxed digit.

Test Plan:
- Reset: rst_n = 0 mid-scan -> an = 8'hFF, seg = 7'h7F and dp = 1 in the same cycle. After release, slot 0 (unit C) appears with an = 8'hFE after DIV cycles minus the guard.
- DIV = 4; load 0,2,5,3, sign 0, c_f 0 (25.3 C):
  - slot 0 = 46, slot 1 = 30, slot 2 = 12 with dp = 0, slot 3 = 24, slots 4 and 5 = 7F;
  - an[i] = 0 for 3 of 4 cycles per slot.
- Load 0,0,0,5, sign 1, c_f 1 (-0.5 F):
  - slot 0 = 0E, slot 1 = 12, slot 2 = 40 with dp = 0, slot 3 = 3F, slots 4 and 5 = 7F.
- Load 1,2,3,4, sign 1:
  - slot 5 = 3F, slot 4 = 79, slot 3 = 24, slot 2 = 30, slot 1 = 19.
- load coincident with a slot wrap, digits changing 1 -> 7:
  - the next slot shows the new value; no mixed old/new frame appears after that cycle.
- Invalid ones = 4'hB -> slot 1 = 06. With TDISP_SCAN_DIM_EN, DIV = 16, bright = 1 -> anode active for exactly 3 cycles per slot.
